cmd_frame_decoder_n: RTL and testbench



---
 rtl/cmd_frame_decoder_n.sv | 238 +++++++++++++++++++++++
 tb/tb_cmd_frame_decoder_n.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_frame_decoder_n.sv
// Command-frame decoder: forwards every received byte to the host-CPU transmit path and
// parses fixed-length frames that drive host selection, per-channel CPU resets and power enables.
module cmd_frame_decoder_n #(
    parameter int         NCH          = 2,
    parameter int         PAYLOAD_LEN  = 4,
    parameter logic [7:0] BOARD_ID     = 8'hAB,
    parameter logic [7:0] HDR0         = 8'hEB,
    parameter logic [7:0] HDR1         = 8'h90,
    parameter logic [7:0] TAIL0        = 8'h09,
    parameter logic [7:0] TAIL1        = 8'hD7,
    parameter int         GAP_CYCLES   = 1000,
    parameter int         RESET_CYCLES = 50_000_000,
    localparam int        CW           = $clog2(NCH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    rx_data,
    input  logic          rx_valid,
    output logic [7:0]    tx_data,
    output logic          tx_push,
    output logic [CW-1:0] host,
    output logic          force_swi,
    output logic [NCH-1:0] rst_out,
    output logic [NCH-1:0] pwr_on,
    output logic          done,
    output logic [2:0]    status
);
    localparam int FRAME_LEN = PAYLOAD_LEN + 4;
    localparam int CNT_W     = $clog2(FRAME_LEN + 2);
    localparam int GAP_W     = $clog2(GAP_CYCLES + 1);
    localparam int RST_W     = $clog2(RESET_CYCLES + 1);

    localparam logic [CNT_W-1:0] LAST_PAY_IDX = CNT_W'(PAYLOAD_LEN + 1);
    localparam logic [CNT_W-1:0] TAIL0_IDX    = CNT_W'(PAYLOAD_LEN + 2);
    localparam logic [CNT_W-1:0] TAIL1_IDX    = CNT_W'(PAYLOAD_LEN + 3);
    localparam logic [CNT_W-1:0] FRAME_LEN_C  = CNT_W'(FRAME_LEN);
    localparam logic [GAP_W-1:0] GAP_LAST     = GAP_W'(GAP_CYCLES - 1);
    localparam logic [RST_W-1:0] RST_LOAD     = RST_W'(RESET_CYCLES);
    localparam logic [7:0]       NCH_B        = 8'(NCH);

    localparam logic [7:0] CMD_SEL     = 8'h0A;
    localparam logic [7:0] CMD_RST     = 8'hA0;
    localparam logic [7:0] CMD_RST_ALL = 8'hAB;
    localparam logic [7:0] CMD_PWR_ON  = 8'hAA;
    localparam logic [7:0] CMD_PWR_OFF = 8'h55;

    localparam logic [2:0] ST_OK      = 3'd0;
    localparam logic [2:0] ST_HDR     = 3'd1;
    localparam logic [2:0] ST_LEN     = 3'd2;
    localparam logic [2:0] ST_SUM     = 3'd3;
    localparam logic [2:0] ST_TAIL    = 3'd4;
    localparam logic [2:0] ST_REFUSED = 3'd5;
    localparam logic [2:0] ST_ID      = 3'd6;
    localparam logic [2:0] ST_CMD     = 3'd7;

    typedef enum logic [2:0] {IDLE, HDR, BODY, TAIL, WAIT_GAP, DISCARD, EXEC} state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [7:0]       sum_reg, sum_next;
    logic [2:0]       err_reg, err_next;
    logic [7:0]       id_reg, id_next, cmd_reg, cmd_next, arg_reg, arg_next;
    logic [GAP_W-1:0] gap_reg, gap_next;

    logic [7:0]       tx_data_reg;
    logic             tx_push_reg, force_swi_reg, done_reg;
    logic [CW-1:0]    host_reg;
    logic [NCH-1:0]   pwr_on_reg;
    logic [2:0]       status_reg;

    // Per-byte check: classify the incoming byte by its position in the frame.
    logic             starting, is_payload;
    logic [CNT_W-1:0] idx;
    logic [2:0]       byte_err;
    state_t           byte_state;

    always_comb begin
        starting   = (state_reg == IDLE) || (state_reg == EXEC);
        idx        = starting ? '0 : count_reg;
        byte_err   = ST_OK;
        byte_state = BODY;
        is_payload = 1'b0;
        if (idx == '0) begin
            byte_state = HDR;
            if (rx_data != HDR0) byte_err = ST_HDR;
        end else if (idx == CNT_W'(1)) begin
            if (rx_data != HDR1) byte_err = ST_HDR;
        end else if (idx <= LAST_PAY_IDX) begin
            is_payload = 1'b1;
            if (idx == LAST_PAY_IDX) byte_state = TAIL;
        end else if (idx == TAIL0_IDX) begin
            byte_state = TAIL;
            if (rx_data != TAIL0) byte_err = ST_TAIL;
        end else if (idx == TAIL1_IDX) begin
            byte_state = WAIT_GAP;
            if (rx_data != TAIL1) byte_err = ST_TAIL;
        end else begin
            byte_err = ST_LEN;
        end
    end

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        sum_next   = sum_reg;
        err_next   = err_reg;
        id_next    = id_reg;
        cmd_next   = cmd_reg;
        arg_next   = arg_reg;
        gap_next   = gap_reg;
        if (rx_valid) begin
            gap_next = '0;
            if (state_reg != DISCARD) begin
                count_next = idx + CNT_W'(1);
                sum_next   = (starting ? 8'h00 : sum_reg) + (is_payload ? rx_data : 8'h00);
                err_next   = byte_err;
                state_next = (byte_err != ST_OK) ? DISCARD : byte_state;
                if (idx == CNT_W'(3)) id_next  = rx_data;
                if (idx == CNT_W'(4)) cmd_next = rx_data;
                if (idx == CNT_W'(5)) arg_next = rx_data;
            end
        end else if ((state_reg == IDLE) || (state_reg == EXEC)) begin
            state_next = IDLE;
        end else if (gap_reg == GAP_LAST) begin
            state_next = EXEC;
        end else begin
            gap_next = gap_reg + GAP_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            count_reg <= '0;
            sum_reg   <= '0;
            err_reg   <= ST_OK;
            id_reg    <= '0;
            cmd_reg   <= '0;
            arg_reg   <= '0;
            gap_reg   <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            sum_reg   <= sum_next;
            err_reg   <= err_next;
            id_reg    <= id_next;
            cmd_reg   <= cmd_next;
            arg_reg   <= arg_next;
            gap_reg   <= gap_next;
        end
    end

    // Frame verdict, evaluated during EXEC in precedence order.
    logic [CW-1:0] arg_sel;
    logic          cmd_known, exec_go;
    logic [2:0]    verdict;

    always_comb begin
        arg_sel   = arg_reg[CW-1:0];
        cmd_known = (cmd_reg == CMD_SEL) || (cmd_reg == CMD_RST) || (cmd_reg == CMD_RST_ALL) ||
                    (cmd_reg == CMD_PWR_ON) || (cmd_reg == CMD_PWR_OFF);
        if (err_reg != ST_OK)
            verdict = err_reg;
        else if (count_reg != FRAME_LEN_C)
            verdict = ST_LEN;
        else if (sum_reg != 8'h00)
            verdict = ST_SUM;
        else if (id_reg != BOARD_ID)
            verdict = ST_ID;
        else if (!cmd_known || (arg_reg >= NCH_B))
            verdict = ST_CMD;
        else if (((cmd_reg == CMD_RST) || (cmd_reg == CMD_PWR_OFF)) && (arg_sel == host_reg))
            verdict = ST_REFUSED;
        else
            verdict = ST_OK;
        exec_go = (state_reg == EXEC) && (verdict == ST_OK);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_data_reg   <= '0;
            tx_push_reg   <= 1'b0;
            host_reg      <= '0;
            force_swi_reg <= 1'b0;
            pwr_on_reg    <= '1;
            done_reg      <= 1'b0;
            status_reg    <= ST_OK;
        end else begin
            tx_push_reg   <= rx_valid;
            if (rx_valid) tx_data_reg <= rx_data;
            done_reg      <= (state_reg == EXEC);
            force_swi_reg <= 1'b0;
            if (state_reg == EXEC) status_reg <= verdict;
            if (exec_go) begin
                case (cmd_reg)
                    CMD_SEL: begin
                        host_reg      <= arg_sel;
                        force_swi_reg <= 1'b1;
                    end
                    CMD_RST_ALL: host_reg <= arg_sel;
                    CMD_PWR_ON:  pwr_on_reg[arg_sel] <= 1'b1;
                    CMD_PWR_OFF: pwr_on_reg[arg_sel] <= 1'b0;
                    default: ;
                endcase
            end
        end
    end

    // One down-counter per channel; a new trigger reloads it mid-pulse.
    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_rst
            logic             trigger;
            logic [RST_W-1:0] cnt_reg;

            assign trigger = exec_go && ((cmd_reg == CMD_RST_ALL) ||
                                         ((cmd_reg == CMD_RST) && (arg_sel == CW'(gi))));

            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    cnt_reg <= '0;
                else if (trigger)
                    cnt_reg <= RST_LOAD;
                else if (cnt_reg != '0)
                    cnt_reg <= cnt_reg - RST_W'(1);
            end

            assign rst_out[gi] = (cnt_reg != '0);
        end
    endgenerate

    assign tx_data   = tx_data_reg;
    assign tx_push   = tx_push_reg;
    assign host      = host_reg;
    assign force_swi = force_swi_reg;
    assign pwr_on    = pwr_on_reg;
    assign done      = done_reg;
    assign status    = status_reg;
endmodule

// File: tb/tb_cmd_frame_decoder_n.sv
// Bench for cmd_frame_decoder_n: frame-level reference model compared every cycle,
// plus directed frames with hand-computed expectations.
module tb_cmd_frame_decoder_n;
    localparam int NCH       = 2;
    localparam int GAP       = 16;
    localparam int RSTC      = 8;
    localparam int FRAME_LEN = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic [7:0] tx_data;
    logic       tx_push;
    logic       host;
    logic       force_swi;
    logic [1:0] rst_out;
    logic [1:0] pwr_on;
    logic       done;
    logic [2:0] status;

    cmd_frame_decoder_n #(.NCH(NCH), .GAP_CYCLES(GAP), .RESET_CYCLES(RSTC)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_push(tx_push), .host(host), .force_swi(force_swi),
        .rst_out(rst_out), .pwr_on(pwr_on), .done(done), .status(status)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: collects frame bytes and judges a frame once the gap has elapsed.
    logic [7:0] frame[$];
    int         cyc = 0;
    int         last_rx_cyc = 0;
    int         rst_until[NCH];
    logic       exp_push, exp_done, exp_force, exp_host;
    logic [7:0] exp_data;
    logic [2:0] exp_status;
    logic [1:0] exp_pwr;

    function automatic logic [2:0] judge();
        int n = frame.size();
        int s = 0;
        for (int i = 0; i < n; i++) begin
            if ((i == 0 && frame[0] != 8'hEB) || (i == 1 && frame[1] != 8'h90)) return 3'd1;
            if ((i == FRAME_LEN-2 && frame[i] != 8'h09) || (i == FRAME_LEN-1 && frame[i] != 8'hD7)) return 3'd4;
            if (i >= FRAME_LEN) return 3'd2;
        end
        if (n != FRAME_LEN) return 3'd2;
        for (int i = 2; i < 6; i++) s += frame[i];
        if (s % 256 != 0) return 3'd3;
        if (frame[3] != 8'hAB) return 3'd6;
        if (!(frame[4] inside {8'h0A, 8'hA0, 8'hAB, 8'hAA, 8'h55}) || frame[5] >= NCH) return 3'd7;
        if ((frame[4] == 8'hA0 || frame[4] == 8'h55) && frame[5] == {7'd0, exp_host}) return 3'd5;
        return 3'd0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            frame.delete();
            exp_push = 1'b0; exp_data = 8'h00; exp_done = 1'b0; exp_force = 1'b0;
            exp_status = 3'd0; exp_host = 1'b0; exp_pwr = 2'b11;
            for (int i = 0; i < NCH; i++) rst_until[i] = 0;
        end else begin
            cyc++;
            exp_done  = 1'b0;
            exp_force = 1'b0;
            exp_push  = rx_valid;
            if (rx_valid) exp_data = rx_data;
            if (frame.size() > 0 && cyc == last_rx_cyc + GAP + 1) begin
                exp_status = judge();
                exp_done   = 1'b1;
                if (exp_status == 3'd0) begin
                    case (frame[4])
                        8'h0A: begin exp_host = frame[5][0]; exp_force = 1'b1; end
                        8'hA0: rst_until[frame[5]] = cyc + RSTC;
                        8'hAB: begin
                            exp_host = frame[5][0];
                            for (int i = 0; i < NCH; i++) rst_until[i] = cyc + RSTC;
                        end
                        8'hAA: exp_pwr[frame[5][0]] = 1'b1;
                        8'h55: exp_pwr[frame[5][0]] = 1'b0;
                        default: ;
                    endcase
                end
                frame.delete();
            end
            if (rx_valid) begin
                frame.push_back(rx_data);
                last_rx_cyc = cyc;
            end
        end
    end

    // Per-cycle compare plus event counters used by the directed checks.
    int push_seen = 0, force_seen = 0, done_seen = 0, rst0_high = 0, rst1_high = 0;

    always @(negedge clk) begin
        if (!rst) begin
            chk("tx_push", tx_push, exp_push);
            chk("tx_data", tx_data, exp_data);
            chk("done", done, exp_done);
            chk("status", status, exp_status);
            chk("host", host, exp_host);
            chk("force_swi", force_swi, exp_force);
            chk("pwr_on", pwr_on, exp_pwr);
            for (int i = 0; i < NCH; i++) chk("rst_out", rst_out[i], (cyc < rst_until[i]) ? 1 : 0);
            if (tx_push)    push_seen++;
            if (force_swi)  force_seen++;
            if (done)       done_seen++;
            if (rst_out[0]) rst0_high++;
            if (rst_out[1]) rst1_high++;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int idle);
        rx_valid = 1'b1;
        rx_data  = b;
        step();
        rx_valid = 1'b0;
        repeat (idle) step();
    endtask

    task automatic send_frame(input logic [63:0] f, input int gap_pos, input int gap_len);
        logic [63:0] v;
        v = f;
        for (int i = 0; i < 8; i++) send_byte(v[63-8*i -: 8], (i == gap_pos) ? gap_len : 0);
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (done !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        if (done !== 1'b1) chk({name, "_timeout"}, 0, 1);
        else chk({name, "_latency"}, cyc - last_rx_cyc, GAP + 1);
    endtask

    initial begin
        repeat (3) step();
        rst = 1'b0;
        chk("reset_tx_push", tx_push, 0);
        chk("reset_tx_data", tx_data, 0);
        chk("reset_host", host, 0);
        chk("reset_pwr_on", pwr_on, 2'b11);
        chk("reset_rst_out", rst_out, 0);
        chk("reset_done", done, 0);
        chk("reset_status", status, 0);
        repeat (2) step();

        // Select host 1
        push_seen = 0; force_seen = 0;
        send_frame(64'hEB904AAB0A0109D7, -1, 0);
        wait_done("sel1");
        chk("sel1_status", status, 0);
        chk("sel1_host", host, 1);
        repeat (3) step();
        chk("sel1_pushes", push_seen, 8);
        chk("sel1_force_pulses", force_seen, 1);

        // Reset non-host channel 0
        rst0_high = 0; rst1_high = 0;
        send_frame(64'hEB90B5ABA00009D7, -1, 0);
        wait_done("rst0");
        chk("rst0_status", status, 0);
        repeat (12) step();
        chk("rst0_width", rst0_high, RSTC);
        chk("rst0_other", rst1_high, 0);

        // Power off the host: refused
        send_frame(64'hEB90FFAB550109D7, -1, 0);
        wait_done("pwroff");
        chk("pwroff_status", status, 5);
        chk("pwroff_pwr_on", pwr_on, 2'b11);
        repeat (3) step();

        // Select host 0
        send_frame(64'hEB904BAB0A0009D7, -1, 0);
        wait_done("sel0");
        chk("sel0_status", status, 0);
        chk("sel0_host", host, 0);
        repeat (3) step();

        // Checksum error
        send_frame(64'hEB904BAB0A0109D7, -1, 0);
        wait_done("csum");
        chk("csum_status", status, 3);
        chk("csum_host", host, 0);
        repeat (3) step();

        // Extra byte after a valid frame
        send_frame(64'hEB904AAB0A0109D7, 7, 5);
        send_byte(8'h00, 0);
        wait_done("extra");
        chk("extra_status", status, 2);
        chk("extra_host", host, 0);
        repeat (3) step();

        // Header error
        send_frame(64'hEB914AAB0A0109D7, -1, 0);
        wait_done("hdr");
        chk("hdr_status", status, 1);
        repeat (3) step();

        // ID mismatch with valid checksum
        force_seen = 0;
        send_frame(64'hEB9049AC0A0109D7, -1, 0);
        wait_done("id");
        chk("id_status", status, 6);
        chk("id_host", host, 0);
        chk("id_pwr_on", pwr_on, 2'b11);
        chk("id_force_pulses", force_seen, 0);
        repeat (3) step();

        // 14 idle clocks mid-frame
        done_seen = 0;
        send_frame(64'hEB904AAB0A0109D7, 3, 14);
        wait_done("gap14");
        chk("gap14_status", status, 0);
        chk("gap14_host", host, 1);
        repeat (3) step();
        chk("gap14_dones", done_seen, 1);

        // Byte on the expiry cycle (15 idle clocks) keeps the frame alive
        done_seen = 0;
        send_frame(64'hEB904BAB0A0009D7, 2, 15);
        wait_done("gap15");
        chk("gap15_status", status, 0);
        chk("gap15_host", host, 0);
        repeat (3) step();
        chk("gap15_dones", done_seen, 1);

        // Next frame's first byte lands on the EXEC cycle
        done_seen = 0;
        send_frame(64'hEB904AAB0A0109D7, 7, GAP);
        send_frame(64'hEB904BAB0A0009D7, -1, 0);
        wait_done("b2b");
        chk("b2b_status", status, 0);
        chk("b2b_host", host, 0);
        repeat (3) step();
        chk("b2b_dones", done_seen, 2);

        // Async reset 3 clocks into a channel-1 reset pulse
        send_frame(64'hEB90B4ABA00109D7, -1, 0);
        wait_done("rst1");
        chk("rst1_status", status, 0);
        repeat (3) step();
        chk("rst1_pulse_active", rst_out, 2'b10);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_out", rst_out, 0);
        chk("async_pwr_on", pwr_on, 2'b11);
        chk("async_status", status, 0);
        chk("async_done", done, 0);
        step();
        rst = 1'b0;
        repeat (20) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end
endmodule
